udp_seq: RTL and testbench

- Parametrised successor to the fixed three-step UDP send sequencer.
- Drives an arbitrary number of start/end handshake steps in order, e.g. I2C read -> packet build -> MAC TX.
- Adds a per-step timeout with error reporting, abort, one-shot/continuous modes, a programmable repeat interval and a per-input end synchroniser.
- Sits between top-level control and the step engines in the Ti180 UDP design.

---
 rtl/udp_seq.sv | 179 +++++++++++++++++
 tb/tb_udp_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/udp_seq.sv
// udp_seq: sequences P_NSTEP start/end handshake steps in order, with a
// per-step end-wait timeout, abort, one-shot/continuous modes and a repeat
// interval between cycles.
//
// Ports:
//   clk, nrst     system clock, asynchronous active-low reset
//   i_enable      sequencer enable (sampled only in IDLE and DONE)
//   i_mode        0 = continuous (repeat after P_WAIT), 1 = one-shot
//   i_ready       downstream ready; starts a cycle from IDLE
//   i_abort       synchronous abort, highest priority in any state
//   i_end         per-step end indications
//   o_start       one-cycle start pulse per step
//   o_busy        high when not in IDLE or DONE
//   o_step        current step index
//   o_timeout     one-cycle pulse on step timeout
//   o_err_step    step index of the last timeout (sticky)
//   o_cycle_cnt   completed full cycles, wrapping
module udp_seq #(
  parameter int                 P_NSTEP     = 3,
  parameter int                 P_CNTW      = 28,
  parameter int                 P_WAIT      = 125000000,
  parameter int                 P_TIMEOUT   = 12500000,
  parameter logic [P_NSTEP-1:0] P_SYNC_MASK = 3'b100
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               i_enable,
  input  logic               i_mode,
  input  logic               i_ready,
  input  logic               i_abort,
  input  logic [P_NSTEP-1:0] i_end,
  output logic [P_NSTEP-1:0] o_start,
  output logic               o_busy,
  output logic [3:0]         o_step,
  output logic               o_timeout,
  output logic [3:0]         o_err_step,
  output logic [15:0]        o_cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAITEND,
    S_ERR,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0]        LAST_STEP = 4'(P_NSTEP - 1);
  localparam bit                TO_EN     = (P_TIMEOUT != 0);
  localparam logic [P_CNTW-1:0] TO_LAST   = P_CNTW'(P_TIMEOUT - 1);
  localparam logic [P_CNTW-1:0] WAIT_LAST = P_CNTW'(P_WAIT - 1);

  state_t              state, state_n;
  logic [3:0]          step, step_n;
  logic [P_CNTW-1:0]   tcnt, tcnt_n;
  logic [P_CNTW-1:0]   wcnt, wcnt_n;
  logic [15:0]         cyc_n;
  logic [3:0]          err_n;
  logic [P_NSTEP-1:0]  start_n;
  logic                to_n;

  logic [P_NSTEP-1:0]  s0, s1, s2, e_reg;
  logic [P_NSTEP-1:0]  e;
  logic [15:0]         e_ext;

  // End synchroniser: every bit is registered, the mask picks which form is used.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s0    <= '0;
      s1    <= '0;
      s2    <= '0;
      e_reg <= '0;
    end else begin
      s0    <= i_end;
      s1    <= s0;
      s2    <= s1;
      e_reg <= s1 & ~s2;
    end
  end

  assign e      = (e_reg & P_SYNC_MASK) | (i_end & ~P_SYNC_MASK);
  // Widened so the 4-bit step index never reaches past the vector.
  assign e_ext  = 16'(e);
  assign o_step = step;
  assign o_busy = (state != S_IDLE) && (state != S_DONE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= S_IDLE;
      step        <= '0;
      tcnt        <= '0;
      wcnt        <= '0;
      o_start     <= '0;
      o_timeout   <= 1'b0;
      o_err_step  <= '0;
      o_cycle_cnt <= '0;
    end else begin
      state       <= state_n;
      step        <= step_n;
      tcnt        <= tcnt_n;
      wcnt        <= wcnt_n;
      o_start     <= start_n;
      o_timeout   <= to_n;
      o_err_step  <= err_n;
      o_cycle_cnt <= cyc_n;
    end
  end

  always_comb begin
    state_n = state;
    step_n  = step;
    tcnt_n  = tcnt;
    wcnt_n  = '0;
    cyc_n   = o_cycle_cnt;
    err_n   = o_err_step;
    start_n = '0;
    to_n    = 1'b0;

    case (state)
      S_IDLE: begin
        step_n = '0;
        tcnt_n = '0;
        if (i_enable && i_ready) state_n = S_START;
      end
      S_START: begin
        tcnt_n  = '0;
        state_n = S_WAITEND;
        for (int unsigned k = 0; k < P_NSTEP; k++) start_n[k] = (step == 4'(k));
      end
      S_WAITEND: begin
        if (e_ext[step]) begin
          tcnt_n = '0;
          if (step == LAST_STEP) begin
            cyc_n   = o_cycle_cnt + 16'd1;
            state_n = i_mode ? S_DONE : S_WAIT;
          end else begin
            step_n  = step + 4'd1;
            state_n = S_START;
          end
        end else if (TO_EN) begin
          // Counter stops at TO_LAST because the state leaves; no wrap.
          tcnt_n = tcnt + 1'b1;
          if (tcnt == TO_LAST) state_n = S_ERR;
        end
      end
      S_ERR: begin
        to_n    = 1'b1;
        err_n   = step;
        tcnt_n  = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt == WAIT_LAST) begin
          state_n = S_IDLE;
          step_n  = '0;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
      end
      S_DONE: begin
        if (!i_enable) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (i_abort) begin
      state_n = S_IDLE;
      step_n  = '0;
      tcnt_n  = '0;
      wcnt_n  = '0;
      start_n = '0;
      to_n    = 1'b0;
      err_n   = o_err_step;
      cyc_n   = o_cycle_cnt;
    end
  end

endmodule

// File: tb/tb_udp_seq.sv
// Testbench for udp_seq: directed stimulus pushes expected start/timeout
// pulses into a queue; a monitor pops and compares each pulse it observes.
module tb_udp_seq;

  logic        clk;
  logic        nrst;
  logic        i_enable;
  logic        i_mode;
  logic        i_ready;
  logic        i_abort;
  logic [2:0]  i_end;
  logic [2:0]  o_start;
  logic        o_busy;
  logic [3:0]  o_step;
  logic        o_timeout;
  logic [3:0]  o_err_step;
  logic [15:0] o_cycle_cnt;

  typedef struct {
    logic        is_to;
    logic [2:0]  vec;
    int          cyc;
    logic [15:0] cnt;
    logic [3:0]  err;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  udp_seq #(
    .P_NSTEP    (3),
    .P_CNTW     (28),
    .P_WAIT     (10),
    .P_TIMEOUT  (20),
    .P_SYNC_MASK(3'b100)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .i_enable   (i_enable),
    .i_mode     (i_mode),
    .i_ready    (i_ready),
    .i_abort    (i_abort),
    .i_end      (i_end),
    .o_start    (o_start),
    .o_busy     (o_busy),
    .o_step     (o_step),
    .o_timeout  (o_timeout),
    .o_err_step (o_err_step),
    .o_cycle_cnt(o_cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  function automatic void push_s(input logic [2:0] v, input int c, input logic [15:0] n);
    exp_t x;
    x.is_to = 1'b0; x.vec = v; x.cyc = c; x.cnt = n; x.err = 4'd0;
    q.push_back(x);
  endfunction

  function automatic void push_t(input int c, input logic [3:0] es, input logic [15:0] n);
    exp_t x;
    x.is_to = 1'b1; x.vec = 3'b000; x.cyc = c; x.cnt = n; x.err = es;
    q.push_back(x);
  endfunction

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: counts posedges and checks every pulse against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (o_start !== 3'b000) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_start at cycle %0d: got o_start=%b, required none", cyc, o_start);
        end else begin
          e = q.pop_front();
          check("start_kind", {31'd0, e.is_to}, 32'd0);
          check("start_vec", {29'd0, o_start}, {29'd0, e.vec});
          check("start_cycle", cyc, e.cyc);
          check("start_cycle_cnt", {16'd0, o_cycle_cnt}, {16'd0, e.cnt});
        end
      end
      if (o_timeout !== 1'b0) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_timeout at cycle %0d: got o_timeout=%b, required none", cyc, o_timeout);
        end else begin
          e = q.pop_front();
          check("timeout_kind", {31'd0, e.is_to}, 32'd1);
          check("timeout_cycle", cyc, e.cyc);
          check("timeout_err_step", {28'd0, o_err_step}, {28'd0, e.err});
          check("timeout_cycle_cnt", {16'd0, o_cycle_cnt}, {16'd0, e.cnt});
        end
      end
    end
  end

  // Stimulus: times are posedge counts; inputs change at negedges.
  initial begin
    nrst = 1'b0; i_enable = 1'b1; i_mode = 1'b0; i_ready = 1'b0;
    i_abort = 1'b0; i_end = 3'b000;
    #2;
    check("rst_start", {29'd0, o_start}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_step", {28'd0, o_step}, 32'd0);
    check("rst_timeout", {31'd0, o_timeout}, 32'd0);
    check("rst_err_step", {28'd0, o_err_step}, 32'd0);
    check("rst_cycle_cnt", {16'd0, o_cycle_cnt}, 32'd0);
    wait_to(2); nrst = 1'b1;

    // Nominal continuous cycle
    wait_to(5);  i_ready = 1'b1; push_s(3'b001, 7, 16'd0);
    wait_to(9);  i_end = 3'b001; push_s(3'b010, 11, 16'd0);
    wait_to(10); i_end = 3'b000;
    wait_to(15); i_end = 3'b010; push_s(3'b100, 17, 16'd0);
    wait_to(16); i_end = 3'b000;
    // synced end: e pulse in cycle 24, WAIT from 25 to 34, restart pulse at 37
    wait_to(21); i_end = 3'b100; push_s(3'b001, 37, 16'd1);
    wait_to(23); i_end = 3'b000;
    wait_to(30);
    check("wait_busy", {31'd0, o_busy}, 32'd1);
    check("wait_step", {28'd0, o_step}, 32'd2);
    check("wait_cycle_cnt", {16'd0, o_cycle_cnt}, 32'd1);

    // Timeout on step 1: WAITEND 43..62, ERR 63, pulse 64, restart 76
    wait_to(41); i_end = 3'b001;
    push_s(3'b010, 43, 16'd1); push_t(64, 4'd1, 16'd1); push_s(3'b001, 76, 16'd1);
    wait_to(42); i_end = 3'b000;
    wait_to(68);
    check("to_wait_busy", {31'd0, o_busy}, 32'd1);
    check("to_err_step", {28'd0, o_err_step}, 32'd1);
    check("to_wait_step", {28'd0, o_step}, 32'd1);

    // End on the last WAITEND cycle of step 0 beats the timeout
    wait_to(95);  i_end = 3'b001; push_s(3'b010, 97, 16'd1);
    wait_to(96);  i_end = 3'b000;
    wait_to(99);  i_end = 3'b010; push_s(3'b100, 101, 16'd1);
    wait_to(100); i_end = 3'b000;
    wait_to(103); i_end = 3'b100; push_s(3'b001, 119, 16'd2);
    wait_to(105); i_end = 3'b000;

    // Abort while step 1 is in START
    wait_to(121); i_end = 3'b001;
    wait_to(122); i_end = 3'b000; i_abort = 1'b1; i_ready = 1'b0;
    wait_to(123); i_abort = 1'b0;
    check("abort_busy", {31'd0, o_busy}, 32'd0);
    check("abort_step", {28'd0, o_step}, 32'd0);
    check("abort_start", {29'd0, o_start}, 32'd0);
    check("abort_cycle_cnt", {16'd0, o_cycle_cnt}, 32'd2);

    // One-shot
    wait_to(126); i_mode = 1'b1; i_ready = 1'b1; push_s(3'b001, 128, 16'd2);
    wait_to(130); i_end = 3'b001; push_s(3'b010, 132, 16'd2);
    wait_to(131); i_end = 3'b000;
    wait_to(134); i_end = 3'b010; push_s(3'b100, 136, 16'd2);
    wait_to(135); i_end = 3'b000;
    wait_to(138); i_end = 3'b100;
    wait_to(140); i_end = 3'b000;
    wait_to(145);
    check("done_busy", {31'd0, o_busy}, 32'd0);
    check("done_cycle_cnt", {16'd0, o_cycle_cnt}, 32'd3);
    wait_to(160); i_enable = 1'b0;
    wait_to(161); i_enable = 1'b1; push_s(3'b001, 163, 16'd3);

    // Asynchronous reset mid-WAITEND
    wait_to(166); nrst = 1'b0;
    #1;
    check("arst_start", {29'd0, o_start}, 32'd0);
    check("arst_busy", {31'd0, o_busy}, 32'd0);
    check("arst_step", {28'd0, o_step}, 32'd0);
    check("arst_timeout", {31'd0, o_timeout}, 32'd0);
    check("arst_err_step", {28'd0, o_err_step}, 32'd0);
    check("arst_cycle_cnt", {16'd0, o_cycle_cnt}, 32'd0);
    wait_to(168); nrst = 1'b1; i_mode = 1'b0; push_s(3'b001, 170, 16'd0);
    wait_to(172); i_end = 3'b001; push_s(3'b010, 174, 16'd0);
    wait_to(173); i_end = 3'b000;

    wait_to(180);
    check("pending_events", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
